hazard_ctrl: RTL

- Central pipeline control unit. Generates the stall, flush and halt controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Its inputs are the EX- and MEM-stage outputs those registers produce: destination register, branch condition, flags and PC_out.
- Resolves three hazard classes:
  - branches taken in MEM,
  - load-use hazards between EX and ID,
  - multi-cycle memory waits.
- Also owns the sticky processor halt.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 56 +++++
 rtl/branch_eval.sv | 29 ++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, branch condition codes and the
// hazard controller state encoding.
package cpu_pkg;

  localparam int PC_W  = 22;
  localparam int REG_W = 5;

  // Branch condition codes carried with a branch instruction.
  localparam logic [2:0] BR_NEQ    = 3'd0;
  localparam logic [2:0] BR_EQ     = 3'd1;
  localparam logic [2:0] BR_GT     = 3'd2;
  localparam logic [2:0] BR_LT     = 3'd3;
  localparam logic [2:0] BR_GTE    = 3'd4;
  localparam logic [2:0] BR_LTE    = 3'd5;
  localparam logic [2:0] BR_OVF    = 3'd6;
  localparam logic [2:0] BR_UNCOND = 3'd7;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_HALT     = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: EX/MEM stage status in, stall/flush/PC control out.
interface hazard_ctrl_if;

  logic [cpu_pkg::REG_W-1:0] ID_src1;
  logic [cpu_pkg::REG_W-1:0] ID_src2;
  logic                      ID_use_src1;
  logic                      ID_use_src2;
  logic [cpu_pkg::REG_W-1:0] EX_dst_reg;
  logic                      EX_use_dst_reg;
  logic                      EX_is_load;
  logic                      MEM_is_branch;
  logic [2:0]                MEM_branch_cond;
  logic                      MEM_flag_ov;
  logic                      MEM_flag_neg;
  logic                      MEM_flag_zero;
  logic [cpu_pkg::PC_W-1:0]  MEM_PC_out;
  logic                      MEM_hlt;
  logic                      mem_req;
  logic                      mem_rdy;

  logic                      stall_pc;
  logic                      stall_IF_ID;
  logic                      stall_ID_EX;
  logic                      stall_EX_MEM;
  logic                      flush_IF_ID;
  logic                      flush_ID_EX;
  logic                      flush_EX_MEM;
  logic                      flush_MEM_WB;
  logic                      pc_sel;
  logic [cpu_pkg::PC_W-1:0]  pc_redirect;
  logic                      hlt;
  logic                      mem_err;

  // Pipeline side: presents stage status, consumes controls.
  modport master (
    output ID_src1, ID_src2, ID_use_src1, ID_use_src2,
    output EX_dst_reg, EX_use_dst_reg, EX_is_load,
    output MEM_is_branch, MEM_branch_cond, MEM_flag_ov, MEM_flag_neg, MEM_flag_zero,
    output MEM_PC_out, MEM_hlt, mem_req, mem_rdy,
    input  stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
    input  flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
    input  pc_sel, pc_redirect, hlt, mem_err
  );

  // Hazard controller side.
  modport slave (
    input  ID_src1, ID_src2, ID_use_src1, ID_use_src2,
    input  EX_dst_reg, EX_use_dst_reg, EX_is_load,
    input  MEM_is_branch, MEM_branch_cond, MEM_flag_ov, MEM_flag_neg, MEM_flag_zero,
    input  MEM_PC_out, MEM_hlt, mem_req, mem_rdy,
    output stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
    output flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
    output pc_sel, pc_redirect, hlt, mem_err
  );

endinterface

// File: rtl/branch_eval.sv
// Branch condition evaluator: condition code + {ov,neg,zero} flags -> condition true.
// Purely combinational so the branch predictor can reuse it.
module branch_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       flag_ov,
  input  logic       flag_neg,
  input  logic       flag_zero,
  output logic       cond_true
);

  // Decode the condition code against the flags.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      BR_NEQ:    cond_true = !flag_zero;
      BR_EQ:     cond_true = flag_zero;
      BR_GT:     cond_true = !flag_zero && !flag_neg;
      BR_LT:     cond_true = flag_neg;
      BR_GTE:    cond_true = !flag_neg;
      BR_LTE:    cond_true = flag_neg || flag_zero;
      BR_OVF:    cond_true = flag_ov;
      BR_UNCOND: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline hazard controller: branch redirect, load-use bubbles,
// memory wait stalls with timeout, and the sticky processor halt.
// Datapath widths come from cpu_pkg so they match the interface.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  localparam int                CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  hz_state_e        state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             hlt_r;
  logic             mem_err_r, mem_err_nxt;

  logic cond_true, taken, load_use, waiting;
  logic stall_pc_s, stall_if_id_s, stall_id_ex_s, stall_ex_mem_s;
  logic flush_if_id_s, flush_id_ex_s, flush_ex_mem_s, flush_mem_wb_s;
  logic pc_sel_s;

  branch_eval u_branch_eval (
    .cond      (bus.MEM_branch_cond),
    .flag_ov   (bus.MEM_flag_ov),
    .flag_neg  (bus.MEM_flag_neg),
    .flag_zero (bus.MEM_flag_zero),
    .cond_true (cond_true)
  );

  assign taken = bus.MEM_is_branch & cond_true;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = bus.EX_is_load & bus.EX_use_dst_reg & (bus.EX_dst_reg != {REG_W{1'b0}}) &
                    ((bus.ID_use_src1 & (bus.ID_src1 == bus.EX_dst_reg)) |
                     (bus.ID_use_src2 & (bus.ID_src2 == bus.EX_dst_reg)));

  // A wait that sees mem_rdy releases this cycle and is treated exactly like RUN.
  assign waiting = (state_r == HZ_MEM_WAIT) && !bus.mem_rdy;

  // Next-state, counter and control decode.
  always_comb begin
    state_nxt      = state_r;
    cnt_nxt        = cnt_r;
    mem_err_nxt    = mem_err_r;
    stall_pc_s     = 1'b0;
    stall_if_id_s  = 1'b0;
    stall_id_ex_s  = 1'b0;
    stall_ex_mem_s = 1'b0;
    flush_if_id_s  = 1'b0;
    flush_id_ex_s  = 1'b0;
    flush_ex_mem_s = 1'b0;
    flush_mem_wb_s = 1'b0;
    pc_sel_s       = 1'b0;
    case (state_r)
      HZ_RUN, HZ_MEM_WAIT: begin
        if (waiting) begin
          stall_pc_s     = 1'b1;
          stall_if_id_s  = 1'b1;
          stall_id_ex_s  = 1'b1;
          stall_ex_mem_s = 1'b1;
          flush_mem_wb_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            mem_err_nxt = 1'b1;
            state_nxt   = HZ_HALT;
            cnt_nxt     = {CNT_W{1'b0}};
          end else begin
            cnt_nxt = cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt = HZ_RUN;
          cnt_nxt   = {CNT_W{1'b0}};
          if (bus.MEM_hlt) begin
            state_nxt     = HZ_HALT;
            stall_pc_s    = 1'b1;
            flush_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
          end else if (taken) begin
            // Younger instrs are squashed, so a coincident load-use is moot.
            pc_sel_s       = 1'b1;
            flush_if_id_s  = 1'b1;
            flush_id_ex_s  = 1'b1;
            flush_ex_mem_s = 1'b1;
          end else if (bus.mem_req && !bus.mem_rdy && !bus.MEM_is_branch) begin
            state_nxt      = HZ_MEM_WAIT;
            stall_pc_s     = 1'b1;
            stall_if_id_s  = 1'b1;
            stall_id_ex_s  = 1'b1;
            stall_ex_mem_s = 1'b1;
            flush_mem_wb_s = 1'b1;
          end else if (load_use) begin
            stall_pc_s    = 1'b1;
            stall_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
          end else begin
            state_nxt = HZ_RUN;
          end
        end
      end
      HZ_HALT: begin
        stall_pc_s     = 1'b1;
        stall_if_id_s  = 1'b1;
        stall_id_ex_s  = 1'b1;
        stall_ex_mem_s = 1'b1;
      end
      default: begin
        state_nxt = HZ_RUN;
        cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, wait counter and sticky halt/error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= HZ_RUN;
      cnt_r     <= {CNT_W{1'b0}};
      hlt_r     <= 1'b0;
      mem_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      hlt_r     <= hlt_r | (state_nxt == HZ_HALT);
      mem_err_r <= mem_err_nxt;
    end
  end

  assign bus.stall_pc     = stall_pc_s;
  assign bus.stall_IF_ID  = stall_if_id_s;
  assign bus.stall_ID_EX  = stall_id_ex_s;
  assign bus.stall_EX_MEM = stall_ex_mem_s;
  assign bus.flush_IF_ID  = flush_if_id_s;
  assign bus.flush_ID_EX  = flush_id_ex_s;
  assign bus.flush_EX_MEM = flush_ex_mem_s;
  assign bus.flush_MEM_WB = flush_mem_wb_s;
  assign bus.pc_sel       = pc_sel_s;
  assign bus.pc_redirect  = pc_sel_s ? bus.MEM_PC_out : {PC_W{1'b0}};
  assign bus.hlt          = hlt_r;
  assign bus.mem_err      = mem_err_r;

endmodule
